// File: rtl/test_run_if.sv
// Configuration, channel status and run-status bundle between a test harness and test_run_controller.
interface test_run_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 64
);
    localparam int unsigned CAUSE_W   = 2;
    localparam int unsigned FAIL_CH_W = 5;

    logic [CNT_W-1:0]     max_cycles;
    logic [CNT_W-1:0]     dump_start;
    logic [CNT_W-1:0]     dump_stop;
    logic [NUM_CH-1:0]    ch_success;
    logic [NUM_CH-1:0]    ch_failure;
    logic                 progress;

    logic                 harness_reset;
    logic [CNT_W-1:0]     cycle_count;
    logic                 dump_en;
    logic                 done;
    logic                 pass;
    logic                 fail;
    logic [CAUSE_W-1:0]   fail_cause;
    logic [FAIL_CH_W-1:0] fail_ch;

    // Harness side: supplies limits and channel status, observes run status.
    modport master (
        output max_cycles, dump_start, dump_stop, ch_success, ch_failure, progress,
        input  harness_reset, cycle_count, dump_en, done, pass, fail, fail_cause, fail_ch
    );

    // Controller side.
    modport slave (
        input  max_cycles, dump_start, dump_stop, ch_success, ch_failure, progress,
        output harness_reset, cycle_count, dump_en, done, pass, fail, fail_cause, fail_ch
    );
endinterface

// File: rtl/test_run_controller.sv
// Test run controller: sequences harness reset, counts cycles, gates the waveform-dump
// window and resolves the run into a sticky PASS or FAIL verdict.
// Optional watchdog compiled in with `define TEST_RUN_CTRL_WATCHDOG_EN.
module test_run_controller #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CNT_W      = 64,
    parameter int unsigned RST_CYCLES = 16,
    parameter int unsigned WDOG_W     = 20
) (
    input  logic       clock,
    input  logic       reset,
    test_run_if.slave  bus
);
    localparam int unsigned CAUSE_W   = 2;
    localparam int unsigned FAIL_CH_W = 5;

    localparam logic [CAUSE_W-1:0] CAUSE_NONE = 2'd0;
    localparam logic [CAUSE_W-1:0] CAUSE_CH   = 2'd1;
    localparam logic [CAUSE_W-1:0] CAUSE_TMO  = 2'd2;
    localparam logic [CAUSE_W-1:0] CAUSE_WDOG = 2'd3;

    typedef enum logic [1:0] {RSTSEQ, RUN, PASS, FAIL} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cycle_count_q, cycle_count_d;
    logic [NUM_CH-1:0]    mask_q, mask_d, mask_next;
    logic                 harness_reset_q, harness_reset_d;
    logic                 dump_en_q, dump_en_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic                 fail_q, fail_d;
    logic [CAUSE_W-1:0]   fail_cause_q, fail_cause_d;
    logic [FAIL_CH_W-1:0] fail_ch_q, fail_ch_d;
    logic [FAIL_CH_W-1:0] fail_idx;
    logic                 timeout;
    logic                 wdog_trip;

`ifdef TEST_RUN_CTRL_WATCHDOG_EN
    localparam logic [WDOG_W-1:0] WDOG_MAX = '1;

    logic [WDOG_W-1:0] wdog_q, wdog_d, wdog_inc;

    // Watchdog: counts RUN cycles without progress; trips when the count reaches all-ones.
    always_comb begin
        wdog_inc  = wdog_q + WDOG_W'(1);
        wdog_d    = wdog_q;
        wdog_trip = 1'b0;
        if (state_q != RUN || bus.progress) begin
            wdog_d = '0;
        end else begin
            wdog_d    = wdog_inc;
            wdog_trip = (wdog_inc == WDOG_MAX);
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clock) begin
        if (!reset) wdog_q <= '0;
        else        wdog_q <= wdog_d;
    end
`else
    logic unused_progress;
    assign wdog_trip       = 1'b0;
    assign unused_progress = ^{bus.progress, 32'(WDOG_W)};
`endif

    // Lowest-index failing channel.
    always_comb begin
        fail_idx = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (bus.ch_failure[i]) fail_idx = FAIL_CH_W'(i);
        end
    end

    assign timeout   = (bus.max_cycles != '0) && (cycle_count_q > bus.max_cycles);
    assign mask_next = mask_q | bus.ch_success;

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        done_d       = done_q;
        pass_d       = pass_q;
        fail_d       = fail_q;
        fail_cause_d = fail_cause_q;
        fail_ch_d    = fail_ch_q;

        cycle_count_d = (cycle_count_q == '1) ? cycle_count_q : cycle_count_q + CNT_W'(1);

        case (state_q)
            RSTSEQ: begin
                if (cycle_count_q >= CNT_W'(RST_CYCLES)) state_d = RUN;
            end
            RUN: begin
                mask_d = mask_next;
                if (|bus.ch_failure) begin
                    state_d      = FAIL;
                    fail_cause_d = CAUSE_CH;
                    fail_ch_d    = fail_idx;
                end else if (wdog_trip) begin
                    state_d      = FAIL;
                    fail_cause_d = CAUSE_WDOG;
                end else if (timeout) begin
                    state_d      = FAIL;
                    fail_cause_d = CAUSE_TMO;
                end else if (&mask_next) begin
                    state_d = PASS;
                end
                if (state_d == FAIL) begin
                    done_d = 1'b1;
                    fail_d = 1'b1;
                end else if (state_d == PASS) begin
                    done_d = 1'b1;
                    pass_d = 1'b1;
                end
            end
            default: ;
        endcase

        harness_reset_d = (state_d == RSTSEQ);
        dump_en_d       = !done_q && (cycle_count_d >= bus.dump_start) &&
                          ((bus.dump_stop == '0) || (cycle_count_d < bus.dump_stop));
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q         <= RSTSEQ;
            cycle_count_q   <= '0;
            mask_q          <= '0;
            harness_reset_q <= 1'b1;
            dump_en_q       <= 1'b0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            fail_q          <= 1'b0;
            fail_cause_q    <= CAUSE_NONE;
            fail_ch_q       <= '0;
        end else begin
            state_q         <= state_d;
            cycle_count_q   <= cycle_count_d;
            mask_q          <= mask_d;
            harness_reset_q <= harness_reset_d;
            dump_en_q       <= dump_en_d;
            done_q          <= done_d;
            pass_q          <= pass_d;
            fail_q          <= fail_d;
            fail_cause_q    <= fail_cause_d;
            fail_ch_q       <= fail_ch_d;
        end
    end

    assign bus.harness_reset = harness_reset_q;
    assign bus.cycle_count   = cycle_count_q;
    assign bus.dump_en       = dump_en_q;
    assign bus.done          = done_q;
    assign bus.pass          = pass_q;
    assign bus.fail          = fail_q;
    assign bus.fail_cause    = fail_cause_q;
    assign bus.fail_ch       = fail_ch_q;
endmodule

// File: doc/test_run_controller.md
TEST_RUN_CONTROLLER -- requirements
Module: test_run_controller

Interface
REQ-001 Parameter NUM_CH, 4, number of independent test-completion channels (1..32).
REQ-002 Parameter CNT_W, 64, width of cycle counter and all cycle-valued inputs.
REQ-003 Parameter RST_CYCLES, 16, cycles the harness reset is held after block reset releases (>=1).
REQ-004 Parameter WDOG_W, 20, width of the watchdog counter (used only when the watchdog is compiled in).
REQ-005 Port clock  input  1  clock, all logic on its rising edge.
REQ-006 Port reset  input  1  reset, synchronous, active-low.
REQ-007 Port max_cycles  input  CNT_W  timeout limit; 0 disables timeout.
REQ-008 Port dump_start  input  CNT_W  first cycle at which the waveform-dump enable asserts.
REQ-009 Port dump_stop  input  CNT_W  cycle at which the dump enable deasserts; 0 means never.
REQ-010 Port ch_success  input  NUM_CH  per-channel success pulse or level, sampled each RUN cycle.
REQ-011 Port ch_failure  input  NUM_CH  per-channel failure pulse or level, sampled each RUN cycle.
REQ-012 Port progress  input  1  DUT liveness pulse, used by the watchdog.
REQ-013 Port harness_reset  output  1  active-high reset driven to the test harness.
REQ-014 Port cycle_count  output  CNT_W  cycles elapsed since block reset released.
REQ-015 Port dump_en  output  1  waveform-dump window enable.
REQ-016 Port done  output  1  run finished (pass or fail), sticky.
REQ-017 Port pass  output  1  run passed, sticky.
REQ-018 Port fail  output  1  run failed, sticky.
REQ-019 Port fail_cause  output  2  0 none, 1 channel failure, 2 timeout, 3 watchdog.
REQ-020 Port fail_ch  output  5  lowest-index failing channel; 0 unless fail_cause==1.

Function
REQ-021 The FSM SHALL have states RSTSEQ, RUN, PASS, FAIL; RSTSEQ is entered on reset.
REQ-022 RSTSEQ: harness_reset=1 for exactly RST_CYCLES cycles after reset deasserts, then go to RUN with harness_reset=0.
REQ-023 cycle_count SHALL increment by 1 every cycle after reset deasserts, including RSTSEQ, PASS and FAIL; it saturates at all-ones.
REQ-024 In RUN, each ch_success bit SHALL set a sticky done-mask bit; entry to PASS occurs the cycle after all NUM_CH mask bits are set.
REQ-025 In RUN, any ch_failure bit SHALL move to FAIL next cycle with cause 1 and fail_ch = lowest set index.
REQ-026 In RUN, when max_cycles!=0 and cycle_count>max_cycles, the FSM SHALL move to FAIL with cause 2.
REQ-027 Same-cycle priority: channel failure > watchdog > timeout > pass completion.
REQ-028 ch_success/ch_failure SHALL be ignored in RSTSEQ, PASS and FAIL.
REQ-029 PASS and FAIL SHALL be terminal until reset; done=1 in both; pass/fail mutually exclusive.
REQ-030 dump_en SHALL be 1 when cycle_count>=dump_start and (dump_stop==0 or cycle_count<dump_stop), in every state, and forced 0 one cycle after done asserts.
REQ-031 All outputs SHALL be registered; the response to any input is visible one cycle after sampling.

Reset
REQ-032 While reset==0: harness_reset=1, cycle_count=0, dump_en=0, done=pass=fail=0, fail_cause=0, fail_ch=0, done-mask cleared, watchdog counter cleared.
REQ-033 Reset asserted mid-run SHALL abort the run and restart RSTSEQ on release, with no sticky state retained.

Configuration
REQ-034 Macro TEST_RUN_CTRL_WATCHDOG_EN: when defined, a WDOG_W counter clears on progress=1 or outside RUN, increments in RUN otherwise, and on reaching all-ones moves to FAIL with cause 3.
REQ-035 Without TEST_RUN_CTRL_WATCHDOG_EN the progress input is unused, no watchdog logic is built, and fail_cause never equals 3.

Verification
REQ-036 NUM_CH=4, RST_CYCLES=16: release reset -> harness_reset high for exactly cycles 1..16, low from cycle 17.
REQ-037 Pulse ch_success bits 0,2,1,3 on separate cycles -> pass=1, done=1 one cycle after bit 3; fail stays 0.
REQ-038 ch_failure=4'b1010 in RUN -> fail=1, fail_cause=1, fail_ch=1; later ch_success ignored.
REQ-039 max_cycles=100, no success -> fail_cause=2 asserted when cycle_count reaches 102 (state change on 101 > 100).
REQ-040 dump_start=20, dump_stop=30 -> dump_en high exactly while cycle_count is 20..29; same-cycle ch_failure and all-success completion -> FAIL cause 1.
REQ-041 With TEST_RUN_CTRL_WATCHDOG_EN, WDOG_W=4, progress held 0 in RUN -> fail_cause=3 after 15 RUN cycles; reset mid-run clears all outputs.
